// File: rtl/frv_mem_responder.sv
// Memory-side responder for one frv_core memory port (imem or dmem).
// Word-addressed SRAM model behind the req/gnt/recv/ack handshake, with a
// bounded in-order response queue, fixed response latency and a grant stall
// input for back-pressure testing.
module frv_mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_gnt,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [3:0]    LAT_C    = 4'(LATENCY);
    // One past the last valid byte, kept in 33 bits so the top of the
    // address space cannot wrap back into the window.
    localparam logic [32:0]   END_ADDR = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

    // Backing store; deliberately not reset so contents survive reset.
    logic [31:0] mem [MEM_WORDS];

    // Response queue entries.
    logic [31:0] q_rdata [DEPTH];
    logic        q_error [DEPTH];
    logic [3:0]  q_age   [DEPTH];
    logic        q_valid [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          addr_err;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          unused_offset;

    // Address decode: word index and out-of-window / misalignment detection.
    always_comb begin
        offset   = mem_addr - BASE_ADDR;
        idx      = offset[AW+1:2];
        addr_err = (mem_addr[1:0] != 2'b00) ||
                   (mem_addr < BASE_ADDR) ||
                   ({1'b0, mem_addr} >= END_ADDR);
    end

    assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

    // Grant never looks at mem_ack: a full queue stays closed this cycle.
    assign mem_gnt   = !reset && !stall && (count < DEPTH_C);
    assign push      = mem_req && mem_gnt;
    assign mem_recv  = q_valid[head] && (q_age[head] == LAT_C);
    assign pop       = mem_recv && mem_ack;
    assign mem_rdata = mem_recv ? q_rdata[head] : 32'h0;
    assign mem_error = mem_recv ? q_error[head] : 1'b0;
    assign busy      = (count != '0);

    // Byte-masked write into the backing store at the accepting edge.
    always_ff @(posedge clock) begin
        if (push && mem_wen && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_strb[b]) begin
                    mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response queue: ageing, in-order pop at the head, push at the tail.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_valid[i] <= 1'b0;
                q_age[i]   <= 4'd0;
                q_rdata[i] <= 32'h0;
                q_error[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (q_valid[i] && (q_age[i] != LAT_C)) begin
                    q_age[i] <= q_age[i] + 4'd1;
                end
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= (head == LAST_PTR) ? '0 : head + PW'(1);
            end
            if (push) begin
                q_valid[tail] <= 1'b1;
                q_age[tail]   <= 4'd0;
                // Reads capture the pre-write word; writes and errors return zero.
                q_rdata[tail] <= (mem_wen || addr_err) ? 32'h0 : mem[idx];
                q_error[tail] <= addr_err;
                tail          <= (tail == LAST_PTR) ? '0 : tail + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_frv_mem_responder.sv
// Self-checking bench for frv_mem_responder: directed scenarios plus a
// randomized phase, compared every cycle against a transaction-level model
// (expected-response queue stamped with accept cycle, plus a memory array).
module tb_frv_mem_responder;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned LATENCY   = 2;
    localparam int unsigned DEPTH     = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clock = ~clock;

    frv_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR),
        .LATENCY   (LATENCY),
        .DEPTH     (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_strb  (mem_strb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_recv  (mem_recv),
        .mem_ack   (mem_ack),
        .mem_error (mem_error),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        int          acc;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mm [MEM_WORDS];
    int          cyc;
    int          chk_cnt;
    int          err_cnt;
    logic [31:0] log_rdata[$];
    logic        log_err[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pattern(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h1357_0000;
    endfunction

    function automatic bit model_recv();
        if (exp_q.size() == 0) return 1'b0;
        return (cyc - exp_q[0].acc) >= int'(LATENCY);
    endfunction

    function automatic bit model_gnt();
        return !stall && (exp_q.size() < int'(DEPTH));
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(BASE_ADDR);
        return (a[1:0] != 2'b00) || (la < lb) || (la >= lb + 64'(MEM_WORDS) * 4);
    endfunction

    task automatic model_accept(input logic w, input logic [31:0] a, input logic [3:0] s,
                                input logic [31:0] d);
        rsp_t r;
        int   i;
        r.acc   = cyc;
        r.error = addr_bad(a);
        r.rdata = 32'h0;
        if (!r.error) begin
            i = int'((a - BASE_ADDR) / 4);
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mm[i][8*b +: 8] = d[8*b +: 8];
            end else begin
                r.rdata = mm[i];
            end
        end
        exp_q.push_back(r);
    endtask

    // One clock: model the edge from the pre-edge inputs, then compare outputs.
    task automatic tick(output bit acc);
        bit          p_req, p_w, p_ack, p_gnt, p_recv, r;
        logic [3:0]  p_s;
        logic [31:0] p_a, p_d, ed;
        logic        ee;
        p_req  = mem_req;
        p_w    = mem_wen;
        p_s    = mem_strb;
        p_a    = mem_addr;
        p_d    = mem_wdata;
        p_ack  = mem_ack;
        p_gnt  = model_gnt();
        p_recv = model_recv();
        if (mem_recv && mem_ack) begin
            log_rdata.push_back(mem_rdata);
            log_err.push_back(mem_error);
        end
        @(posedge clock);
        cyc++;
        #1;
        if (p_recv && p_ack) void'(exp_q.pop_front());
        acc = p_req && p_gnt;
        if (acc) model_accept(p_w, p_a, p_s, p_d);
        r  = model_recv();
        ed = 32'h0;
        ee = 1'b0;
        if (r) begin
            ed = exp_q[0].rdata;
            ee = exp_q[0].error;
        end
        check("gnt", 32'(mem_gnt), 32'(model_gnt()));
        check("recv", 32'(mem_recv), 32'(r));
        check("rdata", mem_rdata, ed);
        check("error", 32'(mem_error), 32'(ee));
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        bit acc;
        int n;
        mem_req   = 1'b1;
        mem_wen   = w;
        mem_addr  = a;
        mem_strb  = s;
        mem_wdata = d;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            tick(acc);
            n++;
        end
        mem_req = 1'b0;
        if (!acc) check("issue_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        mem_ack = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(acc);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 6) return BASE_ADDR + 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
        if (r == 6) return BASE_ADDR + 32'(MEM_WORDS - 1) * 4;
        if (r == 7) return BASE_ADDR + 32'($urandom_range(0, MEM_WORDS - 1)) * 4
                           + 32'($urandom_range(1, 3));
        if (r == 8) return BASE_ADDR + 32'(MEM_WORDS) * 4 + 32'($urandom_range(0, 255)) * 4;
        return 32'hFFFF_FFFC - 32'($urandom_range(0, 15)) * 4;
    endfunction

    initial begin
        bit          acc;
        int          n;
        logic [31:0] held;
        chk_cnt   = 0;
        err_cnt   = 0;
        cyc       = 0;
        reset     = 1'b1;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_strb  = 4'h0;
        mem_wdata = 32'h0;
        mem_addr  = 32'h0;
        mem_ack   = 1'b0;

        // Reset state
        #12;
        check("rst_gnt", 32'(mem_gnt), 32'd0);
        check("rst_recv", 32'(mem_recv), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_error", 32'(mem_error), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Fill memory through the bus
        mem_ack = 1'b1;
        for (int i = 0; i < int'(MEM_WORDS); i++)
            issue(1'b1, BASE_ADDR + 32'(i) * 4, 4'hF, pattern(i));
        issue(1'b1, 32'h0000_000C, 4'hF, 32'hDEAD_BEEF);
        issue(1'b1, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF);
        drain();

        // Single read timing
        issue(1'b0, 32'h0000_000C, 4'h0, 32'h0);
        check("rd_t0_recv", 32'(mem_recv), 32'd0);
        tick(acc);
        check("rd_t1_recv", 32'(mem_recv), 32'd0);
        tick(acc);
        check("rd_t2_recv", 32'(mem_recv), 32'd1);
        check("rd_t2_data", mem_rdata, 32'hDEAD_BEEF);
        check("rd_t2_err", 32'(mem_error), 32'd0);
        tick(acc);
        check("rd_t3_recv", 32'(mem_recv), 32'd0);

        // Byte write then read
        log_rdata.delete();
        log_err.delete();
        issue(1'b1, 32'h0000_0010, 4'b0101, 32'h1122_3344);
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);
        drain();
        check("bw_count", 32'(log_rdata.size()), 32'd2);
        if (log_rdata.size() == 2) begin
            check("bw_wr_rdata", log_rdata[0], 32'h0);
            check("bw_rd_rdata", log_rdata[1], 32'hFF22_FF44);
        end

        // Full queue with ack held low
        log_rdata.delete();
        log_err.delete();
        mem_ack = 1'b0;
        issue(1'b0, 32'h0000_000C, 4'h0, 32'h0);
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);
        mem_req  = 1'b1;
        mem_addr = 32'h0000_0014;
        for (int k = 0; k < 4; k++) begin
            tick(acc);
            check("full_gnt", 32'(mem_gnt), 32'd0);
            check("full_busy", 32'(busy), 32'd1);
        end
        mem_ack = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 10) begin
            tick(acc);
            n++;
        end
        mem_req = 1'b0;
        if (!acc) check("full_third_timeout", 32'(acc), 32'd1);
        drain();
        check("full_count", 32'(log_rdata.size()), 32'd3);
        if (log_rdata.size() == 3) begin
            check("full_rsp0", log_rdata[0], 32'hDEAD_BEEF);
            check("full_rsp1", log_rdata[1], 32'hFF22_FF44);
            check("full_rsp2", log_rdata[2], pattern(5));
        end

        // Error responses; out-of-range writes must not alias into memory
        log_rdata.delete();
        log_err.delete();
        issue(1'b0, 32'h0000_0002, 4'h0, 32'h0);
        issue(1'b1, 32'h0000_1000, 4'hF, 32'hA5A5_A5A5);
        issue(1'b0, 32'h0000_0000, 4'h0, 32'h0);
        issue(1'b1, 32'hFFFF_FFFC, 4'hF, 32'h5A5A_5A5A);
        issue(1'b0, 32'h0000_0FFC, 4'h0, 32'h0);
        drain();
        check("err_count", 32'(log_rdata.size()), 32'd5);
        if (log_rdata.size() == 5) begin
            check("err_mis_flag", 32'(log_err[0]), 32'd1);
            check("err_mis_rdata", log_rdata[0], 32'h0);
            check("err_oor_flag", 32'(log_err[1]), 32'd1);
            check("err_word0_flag", 32'(log_err[2]), 32'd0);
            check("err_word0_kept", log_rdata[2], pattern(0));
            check("err_wrap_flag", 32'(log_err[3]), 32'd1);
            check("err_last_kept", log_rdata[4], pattern(int'(MEM_WORDS) - 1));
        end

        // Stall blocks grant; then hold a response with ack low
        mem_ack  = 1'b0;
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_wen  = 1'b0;
        mem_addr = 32'h0000_000C;
        for (int k = 0; k < 4; k++) begin
            tick(acc);
            check("stall_gnt", 32'(mem_gnt), 32'd0);
            check("stall_busy", 32'(busy), 32'd0);
        end
        stall = 1'b0;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 10) begin
            tick(acc);
            n++;
        end
        mem_req = 1'b0;
        if (!acc) check("stall_resume_timeout", 32'(acc), 32'd1);
        n = 0;
        while (!mem_recv && n < 20) begin
            tick(acc);
            n++;
        end
        check("hold_first", 32'(mem_recv), 32'd1);
        held = mem_rdata;
        for (int k = 0; k < 5; k++) begin
            tick(acc);
            check("hold_recv", 32'(mem_recv), 32'd1);
            check("hold_data", mem_rdata, 32'hDEAD_BEEF);
            check("hold_stable", mem_rdata, held);
        end
        drain();

        // Asynchronous reset with two requests in flight
        mem_ack = 1'b0;
        issue(1'b0, 32'h0000_000C, 4'h0, 32'h0);
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_recv", 32'(mem_recv), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_gnt", 32'(mem_gnt), 32'd0);
        check("arst_rdata", mem_rdata, 32'h0);
        exp_q.delete();
        #1;
        reset = 1'b0;
        mem_ack = 1'b1;
        log_rdata.delete();
        log_err.delete();
        for (int k = 0; k < 5; k++) tick(acc);
        check("arst_no_stale", 32'(log_rdata.size()), 32'd0);
        issue(1'b0, 32'h0000_000C, 4'h0, 32'h0);
        drain();
        check("arst_mem_count", 32'(log_rdata.size()), 32'd1);
        if (log_rdata.size() == 1) check("arst_mem_kept", log_rdata[0], 32'hDEAD_BEEF);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            mem_req   = 1'($urandom_range(0, 1));
            mem_wen   = 1'($urandom_range(0, 1));
            mem_strb  = 4'($urandom_range(0, 15));
            mem_wdata = $urandom;
            mem_addr  = rand_addr();
            mem_ack   = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 7) == 0);
            tick(acc);
        end
        mem_req = 1'b0;
        stall   = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/frv_mem_responder.md
Name: frv_mem_responder

Overview:
- Memory-side responder for one frv_core memory port (imem or dmem), directly downstream of the core's req/gnt/recv/ack bus.
- Replaces free-running random handshake signals with a deterministic word-addressed SRAM model in directed simulation benches.
- Two instances are used per bench, one per port.
- Supports a bounded number of in-order outstanding requests, a fixed response latency, and an external grant stall for back-pressure testing.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words of backing storage.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- LATENCY, 2: cycles from the accepting edge to the earliest recv. Legal range is 1..15.
- DEPTH, 2: maximum outstanding accepted-but-unacknowledged requests. Legal range is 1..4.

Ports:
- clock  in  1  Single clock.
- reset  in  1  Asynchronous, active-high reset.
- stall  in  1  Forces gnt low while high.
- mem_req  in  1  Request valid from core.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  4  Byte write strobes.
- mem_wdata  in  32  Write data.
- mem_addr  in  32  Byte address.
- mem_gnt  out  1  Request accepted.
- mem_recv  out  1  Response valid.
- mem_ack  in  1  Core accepts response.
- mem_error  out  1  Response carries a bus error.
- mem_rdata  out  32  Read response data.
- busy  out  1  One or more requests outstanding.

Behaviour:
- Reset is asynchronous and active-high:
  - Clears the response queue (count = 0), all entry age counters, and all queue pointers.
  - Drives mem_recv=0, mem_error=0, mem_rdata=0, busy=0, mem_gnt=0.
  - The memory array is not reset; contents survive reset.
- Reset mid-operation: all in-flight responses are discarded. No recv is produced for them after reset releases.
- Grant rule: mem_gnt = !reset && !stall && (count < DEPTH). It depends on registered state and stall only, never on mem_ack.
  - When count == DEPTH, gnt stays 0 even if the head response is acknowledged in the same cycle.
- Accept: the transaction is accepted on a rising edge where mem_req && mem_gnt.
- Memory access happens at the accepting edge:
  - Read: captures mem[idx] into the new queue entry.
  - Write: updates the bytes of mem[idx] selected by mem_strb and stores rdata=0 in the entry.
  - idx = (mem_addr - BASE_ADDR) >> 2.
- Error case: if mem_addr[1:0] != 0, or mem_addr < BASE_ADDR, or mem_addr >= BASE_ADDR + 4*MEM_WORDS:
  - The entry is marked error=1 with rdata=0.
  - No memory write occurs.
  - The address arithmetic must not alias on 32-bit wrap.
- Queue: circular FIFO of DEPTH entries, each holding {rdata[31:0], error, age[3:0]}. Head and tail pointers wrap modulo DEPTH.
- Age: a new entry gets age=0. Every valid entry's age increments each cycle, saturating at LATENCY.
- Response: mem_recv = queue non-empty && head.age == LATENCY. mem_rdata and mem_error come from the head.
  - Consequence: with LATENCY=L, recv first asserts L cycles after the accept cycle.
  - When mem_recv=0, mem_rdata=0 and mem_error=0.
- Hold: once asserted, recv, rdata and error stay stable until the edge where mem_recv && mem_ack. That edge pops the head.
- Ordering: responses are strictly in accept order. A younger entry that has already reached LATENCY waits behind the head.
- Back-to-back: when the head pops, the next entry (if aged) presents recv in the very next cycle.
- Simultaneous push and pop in one edge: count is unchanged and both pointers advance.
- mem_ack while mem_recv=0 is ignored.
- busy = (count != 0).
- Read-after-write ordering is guaranteed by accept-time access: a read accepted after a write observes the written data.

Test Plan:
- Single read: LATENCY=2, mem[3]=32'hDEAD_BEEF, req addr 0x0C at cycle 0 with gnt=1, ack held high → recv=1 in cycle 2 with rdata=32'hDEAD_BEEF, error=0; recv=0 in cycle 3.
- Byte write then read: write addr 0x10, strb=4'b0101, wdata=32'h1122_3344 over old 32'hFFFF_FFFF; then read 0x10 → responses in order: write rdata=0, read rdata=32'hFF22_FF44.
- Full queue: DEPTH=2, ack held low, three back-to-back reqs → gnt=0 after 2 accepts and stays 0 while ack is low. Raise ack → first pop occurs, gnt returns the cycle after, third request accepted. Three responses arrive in order.
- Errors: read 0x0000_0002 → error=1, rdata=0. Write to 0x0000_1000 (MEM_WORDS=1024) → error=1 and memory unchanged.
- Stall and hold: stall=1 with req high → gnt stays 0, and accepts resume when stall=0. With ack low for 5 cycles, recv/rdata stay stable for all 5 cycles.
- Async reset mid-flight: two outstanding requests, assert reset between edges → recv, busy and gnt go 0 immediately. After release there is no stale recv, and memory contents are retained.
